// File: rtl/regfile_param.sv
// Parameterised dual-read, single-write register file with optional write-to-read
// forwarding, optional hardwired-zero register 0 and a sequential bulk-clear sweep.
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wrdata,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              sweeping;
  logic              wr_fire;
  logic [DATA_W-1:0] rd_val1;
  logic [DATA_W-1:0] rd_val2;

  function automatic logic is_zero_addr(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == {ADDR_W{1'b0}});
  endfunction

  // Read-side selection: sweep blanks reads, register 0 may be hardwired,
  // and a colliding write in the same cycle can be forwarded.
  function automatic logic [DATA_W-1:0] read_sel(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              busy,
    input logic              fire,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata
  );
    logic [DATA_W-1:0] val;
    if (busy) begin
      val = {DATA_W{1'b0}};
    end else if (is_zero_addr(addr)) begin
      val = {DATA_W{1'b0}};
    end else if ((BYPASS != 0) && fire && (addr == waddr)) begin
      val = wdata;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  // Decode of the write strobe and the two read-side candidates.
  always_comb begin
    sweeping = (state == CLEAR);
    wr_fire  = wr_en && (state == IDLE) && !is_zero_addr(wr_addr);
    rd_val1  = read_sel(rd_addr1, mem[rd_addr1], sweeping, wr_fire, wr_addr, wrdata);
    rd_val2  = read_sel(rd_addr2, mem[rd_addr2], sweeping, wr_fire, wr_addr, wrdata);
  end

  // Clear-sweep next-state and counter logic; cnt saturates at DEPTH-1.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_next = CLEAR;
          cnt_next   = {ADDR_W{1'b0}};
        end else begin
          state_next = IDLE;
          cnt_next   = cnt;
        end
      end
      CLEAR: begin
        if (cnt == {ADDR_W{1'b1}}) begin
          state_next = DONE;
          cnt_next   = cnt;
        end else begin
          state_next = CLEAR;
          cnt_next   = cnt + ADDR_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
        cnt_next   = cnt;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // FSM state, sweep counter and the registered status flags.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      cnt      <= {ADDR_W{1'b0}};
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      clr_busy <= (state_next == CLEAR);
      clr_done <= (state_next == DONE);
    end
  end

  // Storage array: sweep has priority, user writes are only taken in IDLE.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {DATA_W{1'b0}};
      end
    end else if (sweeping) begin
      mem[cnt] <= {DATA_W{1'b0}};
    end else if (wr_fire) begin
      mem[wr_addr] <= wrdata;
    end
  end

  // Registered read ports; hold when rd_en is low.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rdata1 <= {DATA_W{1'b0}};
      rdata2 <= {DATA_W{1'b0}};
    end else if (rd_en) begin
      rdata1 <= rd_val1;
      rdata2 <= rd_val2;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: a forwarding instance and a non-forwarding instance share
// stimulus; a vector table feeds a scoreboard queue, then clear and reset sequences.
module tb_regfile_param;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          nrst;
  logic          rd_en;
  logic          wr_en;
  logic          clr_req;
  logic [AW-1:0] rd_addr1;
  logic [AW-1:0] rd_addr2;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wrdata;
  logic [DW-1:0] rdata1;
  logic [DW-1:0] rdata2;
  logic [DW-1:0] rdata1_nb;
  logic [DW-1:0] rdata2_nb;
  logic          clr_busy;
  logic          clr_done;
  logic          clr_busy_nb;
  logic          clr_done_nb;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wrdata;
    logic          rd_en;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
    logic [DW-1:0] n1;
    logic [DW-1:0] n2;
  } vec_t;

  typedef struct {
    string         name;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
    logic [DW-1:0] n1;
    logic [DW-1:0] n2;
  } exp_t;

  vec_t vecs[13];
  exp_t sb[$];

  regfile_param #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1), .ZERO_REG(1)) dut (
    .clk(clk), .nrst(nrst), .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rdata1(rdata1), .rdata2(rdata2), .wr_en(wr_en), .wr_addr(wr_addr), .wrdata(wrdata),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  regfile_param #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0), .ZERO_REG(1)) dut_nb (
    .clk(clk), .nrst(nrst), .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rdata1(rdata1_nb), .rdata2(rdata2_nb), .wr_en(wr_en), .wr_addr(wr_addr), .wrdata(wrdata),
    .clr_req(clr_req), .clr_busy(clr_busy_nb), .clr_done(clr_done_nb)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rd_en    = 1'b0;
    wr_en    = 1'b0;
    clr_req  = 1'b0;
    rd_addr1 = 5'd0;
    rd_addr2 = 5'd0;
    wr_addr  = 5'd0;
    wrdata   = 32'h0;
  endtask

  // Pop the oldest expectation and compare it against both instances.
  task automatic sb_compare();
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_empty: got 0 entries, want 1");
    end else begin
      e = sb.pop_front();
      check({e.name, ".rdata1"}, rdata1, e.e1);
      check({e.name, ".rdata2"}, rdata2, e.e2);
      check({e.name, ".nb_rdata1"}, rdata1_nb, e.n1);
      check({e.name, ".nb_rdata2"}, rdata2_nb, e.n2);
    end
  endtask

  // Drive one read cycle, queue its expectation and compare after the edge.
  task automatic read_cycle(input string name, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                            input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    rd_en    = 1'b1;
    rd_addr1 = a1;
    rd_addr2 = a2;
    sb.push_back('{name, e1, e2, e1, e2});
    @(posedge clk); #1;
    rd_en = 1'b0;
    sb_compare();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    int busy_cycles;
    int done_pulses;

    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0};
    vecs[2]  = '{1'b1, 5'd0,  32'h12345678, 1'b1, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
    vecs[4]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 1'b1, 5'd7,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,        32'h0};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd5,  32'hA5A5A5A5, 32'hDEADBEEF, 32'hA5A5A5A5, 32'hDEADBEEF};
    vecs[6]  = '{1'b1, 5'd7,  32'h11111111, 1'b0, 5'd7,  5'd5,  32'hA5A5A5A5, 32'hDEADBEEF, 32'hA5A5A5A5, 32'hDEADBEEF};
    vecs[7]  = '{1'b1, 5'd5,  32'h22222222, 1'b0, 5'd7,  5'd5,  32'hA5A5A5A5, 32'hDEADBEEF, 32'hA5A5A5A5, 32'hDEADBEEF};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd7,  5'd5,  32'hA5A5A5A5, 32'hDEADBEEF, 32'hA5A5A5A5, 32'hDEADBEEF};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd5,  32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222};
    vecs[10] = '{1'b1, 5'd3,  32'h00000033, 1'b1, 5'd3,  5'd4,  32'h00000033, 32'h0,        32'h0,        32'h0};
    vecs[11] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd31, 5'd3,  32'hFFFFFFFF, 32'h00000033, 32'h0,        32'h00000033};
    vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};

    idle_inputs();
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.rdata1", rdata1, 32'h0);
    check("reset.rdata2", rdata2, 32'h0);
    check("reset.clr_busy", {31'h0, clr_busy}, 32'h0);
    check("reset.clr_done", {31'h0, clr_done}, 32'h0);
    nrst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      wr_en    = vecs[i].wr_en;
      wr_addr  = vecs[i].wr_addr;
      wrdata   = vecs[i].wrdata;
      rd_en    = vecs[i].rd_en;
      rd_addr1 = vecs[i].a1;
      rd_addr2 = vecs[i].a2;
      sb.push_back('{$sformatf("vec%0d", i), vecs[i].e1, vecs[i].e2, vecs[i].n1, vecs[i].n2});
      @(posedge clk); #1;
      sb_compare();
    end
    idle_inputs();

    // Fill 1..31 with their index, spot-check, then sweep.
    for (int i = 1; i < 32; i++) begin
      wr_en   = 1'b1;
      wr_addr = AW'(i);
      wrdata  = DW'(i);
      @(posedge clk); #1;
    end
    idle_inputs();
    read_cycle("fill", 5'd17, 5'd31, 32'd17, 32'd31);

    clr_req = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 5'd9;
    wrdata  = 32'h00000099;
    @(posedge clk); #1;
    idle_inputs();
    check("clr_start.busy", {31'h0, clr_busy}, 32'h1);

    busy_cycles = 0;
    done_pulses = 0;
    for (int k = 0; k < 40; k++) begin
      if (clr_busy) busy_cycles++;
      if (clr_done) done_pulses++;
      idle_inputs();
      if (k == 5) begin
        rd_en    = 1'b1;
        rd_addr1 = 5'd31;
        rd_addr2 = 5'd9;
      end else if (k == 10) begin
        clr_req = 1'b1;
      end else if (k == 25) begin
        wr_en   = 1'b1;
        wr_addr = 5'd3;
        wrdata  = 32'h00000BAD;
      end
      @(posedge clk); #1;
      if (k == 5) begin
        check("sweep_read.rdata1", rdata1, 32'h0);
        check("sweep_read.rdata2", rdata2, 32'h0);
      end
    end
    idle_inputs();
    check("sweep.busy_cycles", busy_cycles, 32);
    check("sweep.done_pulses", done_pulses, 1);

    for (int i = 0; i < 32; i++) begin
      read_cycle($sformatf("cleared%0d", i), AW'(i), AW'(31 - i), 32'h0, 32'h0);
    end

    // Abort a sweep with reset at sweep cycle 10.
    wr_en   = 1'b1;
    wr_addr = 5'd4;
    wrdata  = 32'h00000044;
    @(posedge clk); #1;
    idle_inputs();
    read_cycle("pre_abort", 5'd4, 5'd4, 32'h44, 32'h44);
    clr_req = 1'b1;
    @(posedge clk); #1;
    clr_req = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    nrst = 1'b0;
    #1;
    check("abort.rdata1", rdata1, 32'h0);
    check("abort.rdata2", rdata2, 32'h0);
    check("abort.busy", {31'h0, clr_busy}, 32'h0);
    check("abort.done", {31'h0, clr_done}, 32'h0);
    @(negedge clk);
    nrst = 1'b1;
    busy_cycles = 0;
    done_pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (clr_busy) busy_cycles++;
      if (clr_done) done_pulses++;
    end
    check("post_abort.busy_cycles", busy_cycles, 0);
    check("post_abort.done_pulses", done_pulses, 0);

    wr_en    = 1'b1;
    wr_addr  = 5'd6;
    wrdata   = 32'h00000066;
    rd_en    = 1'b1;
    rd_addr1 = 5'd4;
    rd_addr2 = 5'd6;
    sb.push_back('{"post_abort_fwd", 32'h0, 32'h66, 32'h0, 32'h0});
    @(posedge clk); #1;
    idle_inputs();
    sb_compare();
    read_cycle("post_abort_rd", 5'd6, 5'd4, 32'h66, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
